// File: rtl/hci_bank_arbiter_mp.sv
// Per-bank N-group arbiter for the TCDM heterogeneous interconnect.
// Programmable priority order, per-(group,bank) starvation counters and a registered response path.
module hci_bank_arbiter_mp #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_MEM = 16,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned BW    = 8,
    parameter int unsigned IW    = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          ctrl_invert_i,
    input  logic [CNT_W-1:0]              ctrl_max_stall_i,
    input  logic [N_IN*N_MEM-1:0]         in_req_i,
    output logic [N_IN*N_MEM-1:0]         in_gnt_o,
    input  logic [N_IN*N_MEM*AW-1:0]      in_add_i,
    input  logic [N_IN*N_MEM-1:0]         in_wen_i,
    input  logic [N_IN*N_MEM*(DW/BW)-1:0] in_be_i,
    input  logic [N_IN*N_MEM*DW-1:0]      in_data_i,
    input  logic [N_IN*N_MEM*IW-1:0]      in_id_i,
    output logic [N_IN*N_MEM-1:0]         in_r_valid_o,
    output logic [N_IN*N_MEM*DW-1:0]      in_r_data_o,
    output logic [N_IN*N_MEM*IW-1:0]      in_r_id_o,
    output logic [N_MEM-1:0]              mem_req_o,
    input  logic [N_MEM-1:0]              mem_gnt_i,
    output logic [N_MEM*AW-1:0]           mem_add_o,
    output logic [N_MEM-1:0]              mem_wen_o,
    output logic [N_MEM*(DW/BW)-1:0]      mem_be_o,
    output logic [N_MEM*DW-1:0]           mem_data_o,
    input  logic [N_MEM*DW-1:0]           mem_r_data_i
);

    localparam int unsigned BEW   = DW / BW;
    localparam int unsigned NG    = N_IN * N_MEM;
    localparam int unsigned WIN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [NG-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_MEM-1:0]            pend_q, pend_d;
    logic [N_MEM-1:0][WIN_W-1:0] rwin_q, rwin_d;
    logic [N_MEM-1:0][IW-1:0]    rid_q, rid_d;

    logic [N_MEM-1:0]            any_req, starved;
    logic [N_MEM-1:0][WIN_W-1:0] win_req, win_st, win;
    logic [NG-1:0]               gnt;

    // Walk groups from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int unsigned g, i, sel;
        any_req    = '0;
        starved    = '0;
        win_req    = '0;
        win_st     = '0;
        win        = '0;
        gnt        = '0;
        mem_req_o  = '0;
        mem_add_o  = '0;
        mem_wen_o  = '0;
        mem_be_o   = '0;
        mem_data_o = '0;
        for (int unsigned b = 0; b < N_MEM; b++) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                g = ctrl_invert_i ? k : (N_IN - 1 - k);
                i = g * N_MEM + b;
                if (in_req_i[i]) begin
                    any_req[b] = 1'b1;
                    win_req[b] = WIN_W'(g);
                    if (ctrl_max_stall_i != '0 && cnt_q[i] >= ctrl_max_stall_i) begin
                        starved[b] = 1'b1;
                        win_st[b]  = WIN_W'(g);
                    end
                end
            end
            win[b] = starved[b] ? win_st[b] : win_req[b];
            sel    = 32'(win[b]) * N_MEM + b;
            mem_req_o[b] = any_req[b];
            if (any_req[b]) begin
                mem_add_o[b*AW +: AW]    = in_add_i[sel*AW +: AW];
                mem_wen_o[b]             = in_wen_i[sel];
                mem_be_o[b*BEW +: BEW]   = in_be_i[sel*BEW +: BEW];
                mem_data_o[b*DW +: DW]   = in_data_i[sel*DW +: DW];
                gnt[sel]                 = mem_gnt_i[b];
            end
        end
    end

    assign in_gnt_o = gnt;

    always_comb begin
        int unsigned i, sel;
        cnt_d  = cnt_q;
        pend_d = '0;
        rwin_d = rwin_q;
        rid_d  = rid_q;
        for (int unsigned b = 0; b < N_MEM; b++) begin
            sel = 32'(win[b]) * N_MEM + b;
            if (any_req[b] && mem_gnt_i[b]) begin
                pend_d[b] = 1'b1;
                rwin_d[b] = win[b];
                rid_d[b]  = in_id_i[sel*IW +: IW];
            end
            for (int unsigned g = 0; g < N_IN; g++) begin
                i = g * N_MEM + b;
                if (!in_req_i[i] || gnt[i]) begin
                    cnt_d[i] = '0;
                end else if (mem_gnt_i[b] && cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        if (clear_i) begin
            cnt_d  = '0;
            pend_d = '0;
        end
    end

    always_comb begin
        int unsigned i;
        logic        hit;
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        in_r_id_o    = '0;
        for (int unsigned b = 0; b < N_MEM; b++) begin
            for (int unsigned g = 0; g < N_IN; g++) begin
                i   = g * N_MEM + b;
                hit = pend_q[b] && (rwin_q[b] == WIN_W'(g));
                in_r_valid_o[i] = hit;
                if (hit) begin
                    in_r_data_o[i*DW +: DW] = mem_r_data_i[b*DW +: DW];
                    in_r_id_o[i*IW +: IW]   = rid_q[b];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= '0;
            rwin_q <= '0;
            rid_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            rwin_q <= rwin_d;
            rid_q  <= rid_d;
        end
    end

endmodule

// File: tb/tb_hci_bank_arbiter_mp.sv
// Directed self-checking bench for hci_bank_arbiter_mp with 2 groups and 4 banks.
module tb_hci_bank_arbiter_mp;

    localparam int unsigned N_IN = 2, N_MEM = 4, AW = 32, DW = 32, BW = 8, IW = 8, CNT_W = 8;
    localparam int unsigned BEW = DW / BW, NG = N_IN * N_MEM;

    logic                    clk = 1'b0, rst = 1'b1, clear = 1'b0, invert = 1'b0;
    logic [CNT_W-1:0]        max_stall = '0;
    logic [NG-1:0]           in_req = '0, in_gnt, in_wen = '0, in_r_valid;
    logic [NG*AW-1:0]        in_add = '0;
    logic [NG*BEW-1:0]       in_be = '0;
    logic [NG*DW-1:0]        in_data = '0, in_r_data;
    logic [NG*IW-1:0]        in_id = '0, in_r_id;
    logic [N_MEM-1:0]        mem_req, mem_gnt = '1, mem_wen;
    logic [N_MEM*AW-1:0]     mem_add;
    logic [N_MEM*BEW-1:0]    mem_be;
    logic [N_MEM*DW-1:0]     mem_data, mem_r_data = '1;

    int n_checks = 0;
    int n_errors = 0;

    hci_bank_arbiter_mp #(
        .N_IN(N_IN), .N_MEM(N_MEM), .AW(AW), .DW(DW), .BW(BW), .IW(IW), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ctrl_invert_i(invert), .ctrl_max_stall_i(max_stall),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_be_i(in_be), .in_data_i(in_data), .in_id_i(in_id),
        .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data), .in_r_id_o(in_r_id),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
        .mem_be_o(mem_be), .mem_data_o(mem_data), .mem_r_data_i(mem_r_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int g, input int b, input logic [7:0] id,
                           input logic [31:0] add, input logic wen);
        int i;
        i = g * N_MEM + b;
        in_req[i]            = 1'b1;
        in_id[i*IW +: IW]    = id;
        in_add[i*AW +: AW]   = add;
        in_wen[i]            = wen;
        in_be[i*BEW +: BEW]  = 4'hF;
        in_data[i*DW +: DW]  = ~add;
    endtask

    task automatic do_clear();
        in_req = '0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic w;
        // Reset state
        tick(); tick();
        check("rst_r_valid", 64'(in_r_valid), 64'h0);
        check("rst_r_data", 64'(|in_r_data), 64'h0);
        check("rst_r_id", 64'(in_r_id), 64'h0);
        rst = 1'b0;
        tick();

        // Fixed priority, no anti-starvation: group 0 always wins bank 2
        for (int k = 0; k < 4; k++) begin
            set_req(0, 2, 8'(8'h10 + k), 32'h100 + 32'(k), 1'b1);
            set_req(1, 2, 8'h20, 32'h200, 1'b0);
            #1;
            check($sformatf("t1_gnt_%0d", k), 64'({in_gnt[6], in_gnt[2]}), 64'b01);
            check($sformatf("t1_add_%0d", k), 64'(mem_add[2*AW +: AW]), 64'h100 + 64'(k));
            tick();
            check($sformatf("t1_rv_%0d", k), 64'({in_r_valid[6], in_r_valid[2]}), 64'b01);
            check($sformatf("t1_rid_%0d", k), 64'(in_r_id[2*IW +: IW]), 64'h10 + 64'(k));
        end
        do_clear();

        // Threshold 3: group 1 wins every 4th accept
        max_stall = 8'd3;
        for (int k = 0; k < 8; k++) begin
            w = (k % 4 == 3);
            set_req(0, 2, 8'(8'h30 + k), 32'h300, 1'b1);
            set_req(1, 2, 8'(8'h40 + k), 32'h400, 1'b1);
            #1;
            check($sformatf("t2_gnt_%0d", k), 64'({in_gnt[6], in_gnt[2]}), w ? 64'b10 : 64'b01);
            tick();
            check($sformatf("t2_rv_%0d", k), 64'({in_r_valid[6], in_r_valid[2]}), w ? 64'b10 : 64'b01);
            check($sformatf("t2_rid_%0d", k), 64'(in_r_id[(w ? 6 : 2)*IW +: IW]),
                  (w ? 64'h40 : 64'h30) + 64'(k));
            if (k == 3) check("t2_cnt1_after_gnt", 64'(dut.cnt_q[6]), 64'h0);
        end
        do_clear();

        // Inverted priority, then back to normal mid-stream
        max_stall = '0;
        invert    = 1'b1;
        set_req(0, 0, 8'h01, 32'h10, 1'b1);
        set_req(1, 0, 8'h02, 32'h20, 1'b1);
        #1;
        check("t3_inv_gnt", 64'({in_gnt[4], in_gnt[0]}), 64'b10);
        check("t3_inv_add", 64'(mem_add[0 +: AW]), 64'h20);
        tick();
        check("t3_inv_rv", 64'({in_r_valid[4], in_r_valid[0]}), 64'b10);
        invert = 1'b0;
        #1;
        check("t3_norm_gnt", 64'({in_gnt[4], in_gnt[0]}), 64'b01);
        tick();
        check("t3_norm_rv", 64'({in_r_valid[4], in_r_valid[0]}), 64'b01);
        in_req = '0;

        // Read response routing
        set_req(0, 1, 8'h5A, 32'h44, 1'b1);
        #1;
        check("t4_mem_req", 64'(mem_req), 64'b0010);
        check("t4_mem_add", 64'(mem_add[1*AW +: AW]), 64'h44);
        check("t4_mem_wen_be", 64'({mem_wen[1], mem_be[1*BEW +: BEW]}), 64'h1F);
        check("t4_mem_data", 64'(mem_data[1*DW +: DW]), 64'hFFFF_FFBB);
        check("t4_gnt", 64'(in_gnt), 64'h02);
        tick();
        in_req = '0;
        mem_r_data[1*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        check("t4_rv", 64'(in_r_valid), 64'h02);
        check("t4_rdata", 64'(in_r_data[1*DW +: DW]), 64'hDEAD_BEEF);
        check("t4_rid", 64'(in_r_id[1*IW +: IW]), 64'h5A);
        check("t4_g1_rdata", 64'(in_r_data[5*DW +: DW]), 64'h0);
        check("t4_g1_rid", 64'(in_r_id[5*IW +: IW]), 64'h0);
        tick();
        check("t4_rv_drop", 64'(in_r_valid), 64'h0);
        do_clear();

        // Memory stall holds counters; release gives 0,0,1 with threshold 2
        max_stall  = 8'd2;
        mem_gnt[3] = 1'b0;
        set_req(0, 3, 8'h61, 32'h600, 1'b1);
        set_req(1, 3, 8'h71, 32'h700, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("t5_stall_gnt_%0d", k), 64'({in_gnt[7], in_gnt[3], mem_req[3]}), 64'b001);
            tick();
        end
        check("t5_stall_cnt", 64'({dut.cnt_q[7], dut.cnt_q[3]}), 64'h0);
        check("t5_stall_rv", 64'(in_r_valid), 64'h0);
        mem_gnt[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = (k % 3 == 2);
            #1;
            check($sformatf("t5_rel_gnt_%0d", k), 64'({in_gnt[7], in_gnt[3]}), w ? 64'b10 : 64'b01);
            tick();
        end
        do_clear();

        // Clear and reset drop an in-flight response
        max_stall = '0;
        set_req(0, 0, 8'h81, 32'h800, 1'b1);
        set_req(1, 0, 8'h91, 32'h900, 1'b1);
        tick();
        check("t6_cnt_pre", 64'(dut.cnt_q[4]), 64'h1);
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        in_req = '0;
        check("t6_clear_rv", 64'(in_r_valid), 64'h0);
        check("t6_clear_cnt", 64'(dut.cnt_q), 64'h0);
        set_req(0, 0, 8'h82, 32'h800, 1'b1);
        set_req(1, 0, 8'h92, 32'h900, 1'b1);
        tick();
        check("t6_pre_rst_rv", 64'(in_r_valid), 64'h01);
        rst = 1'b1;
        #1;
        check("t6_rst_rv", 64'(in_r_valid), 64'h0);
        check("t6_rst_cnt", 64'(dut.cnt_q), 64'h0);
        in_req = '0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_rst_rv", 64'(in_r_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
